// File: rtl/imgop_frame_ctrl.sv
// Frame sequencer for the greyscale inversion unit: streams one frame from the source RAM
// through the two-cycle read+invert path into the destination RAM, with hold and abort.
module imgop_frame_ctrl #(
  parameter int unsigned IMG_W   = 256,
  parameter int unsigned IMG_H   = 256,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RD_BASE = 0,
  parameter int unsigned WR_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        op_data_in,
  input  logic [7:0]        op_data_out,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic [ADDR_W-1:0] pix_count
);

  localparam int unsigned       NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W-1:0] WR_BASE_A = ADDR_W'(WR_BASE);
  // Source-to-destination address offset, modulo 2^ADDR_W
  localparam logic [ADDR_W-1:0] ADDR_OFFS = WR_BASE_A - RD_BASE_A;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              rd_en_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              busy_nxt, done_nxt, aborted_nxt;
  logic [ADDR_W-1:0] pix_nxt;
  logic              v1;
  logic [ADDR_W-1:0] a1;

  assign op_data_in  = mem_rd_data;
  assign mem_wr_data = op_data_out;

  // State, issue and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= RD_BASE_A;
      v1          <= 1'b0;
      a1          <= WR_BASE_A;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= WR_BASE_A;
      pix_count   <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      aborted     <= aborted_nxt;
      mem_rd_en   <= rd_en_nxt;
      mem_rd_addr <= rd_addr_nxt;
      v1          <= mem_rd_en;
      a1          <= mem_rd_addr + ADDR_OFFS;
      mem_wr_en   <= v1;
      if (v1) mem_wr_addr <= a1;
      pix_count   <= pix_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = mem_rd_addr;
    done_nxt    = 1'b0;
    aborted_nxt = aborted;
    pix_nxt     = pix_count + ADDR_W'(v1);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_ISSUE;
          idx_nxt     = '0;
          aborted_nxt = 1'b0;
          pix_nxt     = '0;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = S_DRAIN;
        end else if (!hold) begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = RD_BASE_A + idx;
          idx_nxt     = idx + ADDR_W'(1);
          if (idx == LAST_IDX) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) aborted_nxt = 1'b1;
        // Nothing left in flight once the read strobe and stage 1 are both clear
        if (!mem_rd_en && !v1) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state != S_IDLE) && ((state_nxt == S_ISSUE) || (state_nxt == S_DRAIN));
  end

endmodule

// File: tb/tb_imgop_frame_ctrl.sv
// Scoreboard bench for imgop_frame_ctrl: directed frames push expected reads, writes and
// done events into queues; negedge monitors pop and compare whenever the DUT presents them.
module tb_imgop_frame_ctrl;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  ev_t rdq_a[$];
  ev_t wrq_a[$];
  ev_t dnq_a[$];
  ev_t wrq_b[$];
  ev_t dnq_b[$];

  // DUT A: 4x2 frame, source at 0x10, destination at 0x80
  logic       start_a, hold_a, abort_a;
  logic       busy_a, done_a, aborted_a, rd_en_a, wr_en_a;
  logic [7:0] rd_addr_a, wr_addr_a, pix_a;
  logic [7:0] rd_data_a, op_in_a, op_out_a, wr_data_a;
  logic [7:0] src_a [256];

  imgop_frame_ctrl #(.IMG_W(4), .IMG_H(2), .ADDR_W(8), .RD_BASE(16), .WR_BASE(128)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .hold(hold_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .aborted(aborted_a),
    .mem_rd_en(rd_en_a), .mem_rd_addr(rd_addr_a), .mem_rd_data(rd_data_a),
    .op_data_in(op_in_a), .op_data_out(op_out_a),
    .mem_wr_en(wr_en_a), .mem_wr_addr(wr_addr_a), .mem_wr_data(wr_data_a),
    .pix_count(pix_a)
  );

  // DUT B: 4-bit address space, destination wraps from 0xF to 0x0
  logic       start_b, hold_b, abort_b;
  logic       busy_b, done_b, aborted_b, rd_en_b, wr_en_b;
  logic [3:0] rd_addr_b, wr_addr_b, pix_b;
  logic [7:0] rd_data_b, op_in_b, op_out_b, wr_data_b;
  logic [7:0] src_b [16];

  imgop_frame_ctrl #(.IMG_W(4), .IMG_H(2), .ADDR_W(4), .RD_BASE(0), .WR_BASE(12)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .hold(hold_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .aborted(aborted_b),
    .mem_rd_en(rd_en_b), .mem_rd_addr(rd_addr_b), .mem_rd_data(rd_data_b),
    .op_data_in(op_in_b), .op_data_out(op_out_b),
    .mem_wr_en(wr_en_b), .mem_wr_addr(wr_addr_b), .mem_wr_data(wr_data_b),
    .pix_count(pix_b)
  );

  // Source RAMs with one-cycle read latency and a registered 0xFF-x inversion unit
  initial begin
    rd_data_a = 8'h00; op_out_a = 8'h00; rd_data_b = 8'h00; op_out_b = 8'h00;
    for (int i = 0; i < 256; i++) src_a[i] = 8'(i - 16);
    for (int i = 0; i < 16; i++) src_b[i] = 8'(8'h30 + i);
  end
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= src_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= src_b[rd_addr_b];
    op_out_a <= 8'hFF - op_in_a;
    op_out_b <= 8'hFF - op_in_b;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected events for a frame started at edge k: reads from cycle k+1, a gap of skip_len
  // cycles before read index skip_at, writes two cycles after each read, done 3 after last read
  task automatic push_a(input int k, input int nrd, input int nwr, input int skip_at,
                        input int skip_len, input bit do_done, input int ab);
    int rc = 0;
    for (int i = 0; i < nrd; i++) begin
      rc = k + 1 + i + ((i >= skip_at) ? skip_len : 0);
      rdq_a.push_back('{rc, 16 + i, 0});
      if (i < nwr) wrq_a.push_back('{rc + 2, 128 + i, 255 - i});
    end
    if (do_done) dnq_a.push_back('{rc + 3, nrd, ab});
  endtask

  task automatic begin_start_a(output int k);
    @(negedge clk);
    start_a = 1'b1;
    k = cyc + 1;
  endtask

  task automatic wait_done_a();
    int t = 0;
    while (!done_a && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) chk("done_a_timeout", 32'(0), 32'(1));
    @(negedge clk);
  endtask

  // Monitor for DUT A
  always @(negedge clk) begin
    ev_t e;
    if (rd_en_a) begin
      if (rdq_a.size() == 0) chk("rd_a_unexpected", 32'(1), 32'(0));
      else begin
        e = rdq_a.pop_front();
        chk("rd_a_cycle", 32'(cyc), 32'(e.cyc));
        chk("rd_a_addr", 32'(rd_addr_a), 32'(e.addr));
      end
    end
    if (wr_en_a) begin
      if (wrq_a.size() == 0) chk("wr_a_unexpected", 32'(1), 32'(0));
      else begin
        e = wrq_a.pop_front();
        chk("wr_a_cycle", 32'(cyc), 32'(e.cyc));
        chk("wr_a_addr", 32'(wr_addr_a), 32'(e.addr));
        chk("wr_a_data", 32'(wr_data_a), 32'(e.data));
      end
    end
    if (done_a) begin
      if (dnq_a.size() == 0) chk("done_a_unexpected", 32'(1), 32'(0));
      else begin
        e = dnq_a.pop_front();
        chk("done_a_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_a_pix", 32'(pix_a), 32'(e.addr));
        chk("done_a_aborted", 32'(aborted_a), 32'(e.data));
        chk("done_a_busy", 32'(busy_a), 32'(0));
      end
    end
  end

  // Monitor for DUT B
  always @(negedge clk) begin
    ev_t e;
    if (wr_en_b) begin
      if (wrq_b.size() == 0) chk("wr_b_unexpected", 32'(1), 32'(0));
      else begin
        e = wrq_b.pop_front();
        chk("wr_b_cycle", 32'(cyc), 32'(e.cyc));
        chk("wr_b_addr", 32'(wr_addr_b), 32'(e.addr));
        chk("wr_b_data", 32'(wr_data_b), 32'(e.data));
      end
    end
    if (done_b) begin
      if (dnq_b.size() == 0) chk("done_b_unexpected", 32'(1), 32'(0));
      else begin
        e = dnq_b.pop_front();
        chk("done_b_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_b_pix", 32'(pix_b), 32'(e.addr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int t;
    rst = 1'b1;
    start_a = 1'b0; hold_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; hold_b = 1'b0; abort_b = 1'b0;
    tick(2);
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_rd_addr", 32'(rd_addr_a), 32'(8'h10));
    chk("rst_wr_addr", 32'(wr_addr_a), 32'(8'h80));
    chk("rst_pix", 32'(pix_a), 32'(0));
    chk("rst_wr_addr_b", 32'(wr_addr_b), 32'(4'hC));
    rst = 1'b0;
    tick(2);

    // Plain frame
    begin_start_a(k);
    push_a(k, 8, 8, 99, 0, 1'b1, 0);
    @(negedge clk); start_a = 1'b0;
    chk("plain_busy_k", 32'(busy_a), 32'(0));
    tick(1);
    chk("plain_busy_k1", 32'(busy_a), 32'(1));
    tick(9);
    chk("plain_busy_k10", 32'(busy_a), 32'(1));
    wait_done_a();
    chk("plain_pix_after", 32'(pix_a), 32'(8));
    chk("plain_aborted", 32'(aborted_a), 32'(0));

    // Hold sampled on edges k+3 and k+4
    begin_start_a(k);
    push_a(k, 8, 8, 2, 2, 1'b1, 0);
    @(negedge clk); start_a = 1'b0;
    tick(2); hold_a = 1'b1;
    tick(2); hold_a = 1'b0;
    wait_done_a();

    // Abort sampled on edge k+4
    begin_start_a(k);
    push_a(k, 3, 3, 99, 0, 1'b1, 1);
    @(negedge clk); start_a = 1'b0;
    tick(3); abort_a = 1'b1;
    tick(1); abort_a = 1'b0;
    wait_done_a();
    chk("abort_held", 32'(aborted_a), 32'(1));
    chk("abort_pix_held", 32'(pix_a), 32'(3));

    // Next start clears aborted; mid-frame start and done-cycle start are ignored
    begin_start_a(k);
    push_a(k, 8, 8, 99, 0, 1'b1, 0);
    @(negedge clk); start_a = 1'b0;
    chk("start_clears_aborted", 32'(aborted_a), 32'(0));
    chk("start_clears_pix", 32'(pix_a), 32'(0));
    tick(4); start_a = 1'b1;
    tick(1); start_a = 1'b0;
    tick(6);
    chk("ign_done_cycle", 32'(done_a), 32'(1));
    start_a = 1'b1;
    tick(1); start_a = 1'b0;
    tick(3);
    chk("ign_start_busy", 32'(busy_a), 32'(0));
    chk("ign_start_rd_q", 32'(rdq_a.size()), 32'(0));

    // Abort while idle must not set aborted
    abort_a = 1'b1;
    tick(1); abort_a = 1'b0;
    tick(1);
    chk("idle_abort", 32'(aborted_a), 32'(0));

    // Hold and abort together: abort wins
    begin_start_a(k);
    push_a(k, 3, 3, 99, 0, 1'b1, 1);
    @(negedge clk); start_a = 1'b0;
    tick(3); hold_a = 1'b1; abort_a = 1'b1;
    tick(1); hold_a = 1'b0; abort_a = 1'b0;
    wait_done_a();
    chk("hold_abort_aborted", 32'(aborted_a), 32'(1));

    // Asynchronous reset in cycle k+5, between edges
    begin_start_a(k);
    push_a(k, 4, 2, 99, 0, 1'b0, 0);
    @(negedge clk); start_a = 1'b0;
    tick(4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'(0));
    chk("mid_rst_rd_en", 32'(rd_en_a), 32'(0));
    chk("mid_rst_wr_en", 32'(wr_en_a), 32'(0));
    chk("mid_rst_pix", 32'(pix_a), 32'(0));
    chk("mid_rst_rd_addr", 32'(rd_addr_a), 32'(8'h10));
    chk("mid_rst_wr_addr", 32'(wr_addr_a), 32'(8'h80));
    tick(2); rst = 1'b0;
    tick(4);
    chk("mid_rst_queues", 32'(rdq_a.size() + wrq_a.size() + dnq_a.size()), 32'(0));

    // Full frame after reset
    begin_start_a(k);
    push_a(k, 8, 8, 99, 0, 1'b1, 0);
    @(negedge clk); start_a = 1'b0;
    wait_done_a();
    chk("post_rst_pix", 32'(pix_a), 32'(8));
    chk("a_queues_empty", 32'(rdq_a.size() + wrq_a.size() + dnq_a.size()), 32'(0));

    // Destination address wrap on DUT B
    @(negedge clk);
    start_b = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 8; i++) wrq_b.push_back('{k + 3 + i, (12 + i) % 16, 255 - (48 + i)});
    dnq_b.push_back('{k + 11, 8, 0});
    @(negedge clk); start_b = 1'b0;
    t = 0;
    while (!done_b && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) chk("done_b_timeout", 32'(0), 32'(1));
    tick(2);
    chk("b_queues_empty", 32'(wrq_b.size() + dnq_b.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imgop_frame_ctrl.md
# imgop_frame_ctrl

Frame sequencer for the 8-bit greyscale pixel inversion unit. On a start pulse it streams every pixel of one frame from a source image memory through the inversion datapath and writes each result to a destination image memory. It tracks in-flight pixels across the fixed two-cycle read-plus-inversion pipeline. It supports hold (pause issue) and abort, and reports completion with a done pulse. It sits between the frame-buffer RAMs and the inversion unit, which it feeds but does not reset.

## Interface
Parameters:
- IMG_W, 256, pixels per row
- IMG_H, 256, rows per frame
- ADDR_W, 16, memory address width; IMG_W*IMG_H must not exceed 2^ADDR_W
- RD_BASE, 0, source frame base address
- WR_BASE, 0, destination frame base address

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame request, sampled in IDLE only
- hold  in  1  while high, no new reads are issued; in-flight pixels still complete
- abort  in  1  stop issuing, drain in-flight pixels, finish with aborted=1
- busy  out  1  high from first issue cycle through the last write cycle
- done  out  1  one-cycle completion pulse
- aborted  out  1  set when a frame ends by abort; held until next accepted start
- mem_rd_en  out  1  source read strobe
- mem_rd_addr  out  ADDR_W  source address
- mem_rd_data  in  8  source pixel, valid the cycle after mem_rd_en
- op_data_in  out  8  to inversion unit; combinational copy of mem_rd_data
- op_data_out  in  8  inversion result, valid one cycle after op_data_in
- mem_wr_en  out  1  destination write strobe
- mem_wr_addr  out  ADDR_W  destination address
- mem_wr_data  out  8  combinational copy of op_data_out
- pix_count  out  ADDR_W  pixels written in the current or last frame

## Operation
- N = IMG_W*IMG_H. Pixels are handled in linear row-major order with index i = 0..N-1.
  - Read address = RD_BASE+i; write address = WR_BASE+i (mod 2^ADDR_W).
- States and transitions:
  - IDLE: go to ISSUE when start=1.
  - ISSUE: go to DRAIN after issuing i=N-1, or when abort=1.
  - DRAIN: go to DONE once the valid pipe is empty.
  - DONE: go to IDLE after one cycle; done=1 during this cycle.
- ISSUE: each cycle with hold=0 and abort=0, assert mem_rd_en with the current address, then increment i. With hold=1, no read is issued and i holds.
- A 2-stage valid/address pipe tracks each read. Stage 2 drives mem_wr_en and mem_wr_addr.
- abort is sampled in ISSUE and DRAIN. It blocks any read in that cycle and sets aborted. Pixels already issued are still written.
- Priority: abort over hold. start is ignored outside IDLE. abort and hold are ignored in IDLE, DONE and when simultaneous with start in IDLE.
- An accepted start clears aborted, pix_count and i.
- pix_count increments on each mem_wr_en and holds its value after done.
- Reset, at any time including mid-frame: go to IDLE and clear the pipe. In-flight pixels are discarded and no further writes occur.

## Timing
- Reset values: busy, done, aborted, mem_rd_en, mem_wr_en = 0; mem_rd_addr = RD_BASE; mem_wr_addr = WR_BASE; pix_count = 0.
- start sampled high at edge k: first mem_rd_en in cycle k+1.
- A read issued in cycle c: mem_rd_data and op_data_in valid in c+1; mem_wr_en/addr/data valid in c+2.
- No hold or abort: reads in cycles k+1..k+N, writes in k+3..k+N+2, done in k+N+3.
  - busy high during k+1..k+N+2, low during the done cycle.
- Each hold cycle delays all subsequent events by one cycle.
- Minimum gap between frames: a start in the done cycle is ignored; the earliest accepted start is the cycle after done.
- Registered outputs: busy, done, aborted, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, pix_count. Pass-through: op_data_in, mem_wr_data.

## Test plan
Small parameters: IMG_W=4, IMG_H=2, RD_BASE=0x10, WR_BASE=0x80. The inversion unit is modelled as a registered 0xFF−x.
- Plain frame: source = 0x00..0x07, start at cycle 0.
  - Reads 0x10..0x17 in cycles 1..8; writes 0x80..0x87 with data 0xFF..0xF8 in cycles 3..10.
  - done in cycle 11; pix_count=8; aborted=0.
- Hold: hold high in cycles 3–4.
  - No read in those cycles; read addresses stay contiguous.
  - All 8 writes correct; done in cycle 13.
- Abort: abort high in cycle 4.
  - Reads 0x10..0x12 only; writes 0x80..0x82 in cycles 3..5.
  - done in cycle 6; aborted=1; pix_count=3. The next start clears aborted.
- Ignored inputs:
  - start pulses mid-frame and in the done cycle are ignored.
  - abort while IDLE does not set aborted.
  - hold and abort both high: abort wins.
- Reset mid-frame: rst asserted in cycle 5 between clock edges.
  - All outputs clear immediately; no mem_wr_en afterwards.
  - The next start runs a full correct 8-pixel frame.
- Address wrap: ADDR_W=4, WR_BASE=0xC. Write addresses are 0xC,0xD,0xE,0xF,0x0..0x3.
